// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } loader_state_t;

    localparam int DEFAULT_LOAD_OFFSET = 4;
    localparam int BYTES_PER_WORD      = 4;

    // Little-endian byte lane select: lane 0 is the least significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_byte_serializer.sv
// rtl/imem_byte_serializer.sv - turns one latched 32-bit word into four consecutive byte writes
module imem_byte_serializer
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic [31:0]       i_word,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wdata,
    output logic              o_done
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic       r_active;
    logic [1:0] r_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_active <= 1'b0;
            r_idx    <= 2'd0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_idx    <= 2'd0;
        end else if (r_active) begin
            if (r_idx == LAST_IDX) begin
                r_active <= 1'b0;
            end
            r_idx <= r_idx + 2'd1;
        end
    end

    // Word and base are held stable by the caller for the whole burst.
    assign o_we    = r_active;
    assign o_addr  = i_base_addr + ADDR_W'(r_idx);
    assign o_wdata = word_byte(i_word, r_idx);
    assign o_done  = r_active && (r_idx == LAST_IDX);

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - streams program words into byte-wide imem, then starts the core
// Optional running XOR of written words behind macro IMEM_LOADER_CHECKSUM_EN.
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LOAD_OFFSET = DEFAULT_LOAD_OFFSET,
    parameter int MAX_WORDS   = (2**ADDR_W - LOAD_OFFSET) / 4
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              core_start,
    output logic [ADDR_W-2:0] word_count,
    output logic              busy,
    output logic              error
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [ADDR_W-2:0] MAX_WC = (ADDR_W-1)'(MAX_WORDS);

    loader_state_t     r_state;
    logic [31:0]       r_word;
    logic              r_last;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-2:0] r_word_count;
    logic              r_busy;
    logic              r_core_start;
    logic              r_error;

    logic              w_accept;
    logic              w_full;
    logic              w_start;
    logic              w_done;
    logic [ADDR_W-1:0] w_next_base;

    assign in_ready    = (r_state == IDLE) && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_full      = (r_word_count == MAX_WC);
    assign w_start     = w_accept && !w_full;
    assign w_next_base = ADDR_W'(LOAD_OFFSET + BYTES_PER_WORD * int'(r_word_count));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_last       <= 1'b0;
            r_base       <= '0;
            r_word_count <= '0;
            r_busy       <= 1'b0;
            r_core_start <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // A full memory drops the word and its last flag.
                        if (w_full) begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= WRITE;
                            r_busy  <= 1'b1;
                            r_word  <= in_data;
                            r_last  <= in_last;
                            r_base  <= w_next_base;
                        end
                    end
                end
                WRITE: begin
                    if (w_done) begin
                        r_word_count <= r_word_count + (ADDR_W-1)'(1);
                        r_busy       <= 1'b0;
                        if (r_last) begin
                            r_state      <= RUN;
                            r_core_start <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                RUN:   r_state <= RUN;
                ERROR: r_state <= ERROR;
                default: r_state <= IDLE;
            endcase
        end
    end

    imem_byte_serializer #(
        .ADDR_W(ADDR_W)
    ) u_serializer (
        .clock      (clock),
        .reset      (reset),
        .i_start    (w_start),
        .i_word     (r_word),
        .i_base_addr(r_base),
        .o_we       (imem_we),
        .o_addr     (imem_addr),
        .o_wdata    (imem_wdata),
        .o_done     (w_done)
    );

    assign core_start = r_core_start;
    assign word_count = r_word_count;
    assign busy       = r_busy;
    assign error      = r_error;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_done) begin
            r_checksum <= r_checksum ^ r_word;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - scoreboard bench for imem_program_loader (ADDR_W=10 and ADDR_W=4 instances)
module tb_imem_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_a, valid_b;
    logic [31:0] in_data;
    logic        in_last;

    logic        ready_a, we_a, start_a, busy_a, err_a;
    logic [9:0]  addr_a;
    logic [7:0]  wdata_a;
    logic [8:0]  wc_a;
    logic        ready_b, we_b, start_b, busy_b, err_b;
    logic [3:0]  addr_b;
    logic [7:0]  wdata_b;
    logic [2:0]  wc_b;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_a, csum_b;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [17:0] q_a[$];
    logic [17:0] q_b[$];
    int          writes_a = 0;
    int          writes_b = 0;
    logic        sel = 1'b0;
    int          exp_count = 0;

    always #5 clock = ~clock;

    imem_program_loader #(.ADDR_W(10)) dut_a (
        .clock(clock), .reset(reset), .in_valid(valid_a), .in_ready(ready_a),
        .in_data(in_data), .in_last(in_last), .imem_we(we_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .core_start(start_a), .word_count(wc_a),
        .busy(busy_a), .error(err_a)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(csum_a)
`endif
    );

    imem_program_loader #(.ADDR_W(4)) dut_b (
        .clock(clock), .reset(reset), .in_valid(valid_b), .in_ready(ready_b),
        .in_data(in_data), .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .core_start(start_b), .word_count(wc_b),
        .busy(busy_b), .error(err_b)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(csum_b)
`endif
    );

    wire cur_ready = sel ? ready_b : ready_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [17:0] e;
        if (we_a === 1'b1) begin
            writes_a++;
            check("sb_pending_a", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("wr_addr_a", 32'(addr_a), 32'(e[17:8]));
                check("wr_data_a", 32'(wdata_a), 32'(e[7:0]));
            end
        end
    end

    always @(negedge clock) begin
        logic [17:0] e;
        if (we_b === 1'b1) begin
            writes_b++;
            check("sb_pending_b", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("wr_addr_b", 32'(addr_b), 32'(e[17:8]));
                check("wr_data_b", 32'(wdata_b), 32'(e[7:0]));
            end
        end
    end

    // Expected little-endian byte writes for the next accepted word.
    task automatic push_word(input logic [31:0] w);
        logic [9:0] a;
        for (int b = 0; b < 4; b++) begin
            a = 10'(4 + 4 * exp_count + b);
            if (sel) q_b.push_back({a, w[8*b +: 8]});
            else     q_a.push_back({a, w[8*b +: 8]});
        end
        exp_count++;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        int n = 0;
        int cap;
        cap = sel ? 3 : 255;
        in_data = w;
        in_last = last;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        @(negedge clock);
        while (!cur_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!cur_ready) check("accept_timeout", 32'd0, 32'd1);
        else if (exp_count < cap) push_word(w);
        @(posedge clock);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        wait_cycles(2);
        reset = 1'b0;
        exp_count = 0;
        q_a.delete();
        q_b.delete();
    endtask

    logic [31:0] prog [7] = '{32'h01000f93, 32'hffe00513, 32'h00150513, 32'hfe051ee3,
                              32'h001f8f93, 32'hfff00e13, 32'h0ff00e93};
    logic [31:0] cw   [3] = '{32'h00100093, 32'h00200113, 32'h00300193};

    initial begin
        int w0;
        int bad;
        int k;
        reset   = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        in_data = 32'h0;
        in_last = 1'b0;
        wait_cycles(2);

        check("rst_in_ready", 32'(ready_a), 32'd0);
        check("rst_we",       32'(we_a),    32'd0);
        check("rst_addr",     32'(addr_a),  32'd0);
        check("rst_wdata",    32'(wdata_a), 32'd0);
        check("rst_start",    32'(start_a), 32'd0);
        check("rst_wc",       32'(wc_a),    32'd0);
        check("rst_busy",     32'(busy_a),  32'd0);
        check("rst_error",    32'(err_a),   32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("rst_checksum", csum_a, 32'd0);
`endif
        reset = 1'b0;
        #1;
        check("ready_after_release", 32'(ready_a), 32'd1);

        // Seven-word program: last byte lands at 31, start follows one cycle later.
        for (int i = 0; i < 6; i++) send_word(prog[i], 1'b0);
        send_word(prog[6], 1'b1);
        check("busy_in_write", 32'(busy_a), 32'd1);
        wait_cycles(3);
        check("last_byte_we",    32'(we_a),    32'd1);
        check("last_byte_addr",  32'(addr_a),  32'd31);
        check("last_byte_data",  32'(wdata_a), 32'h0f);
        check("start_not_early", 32'(start_a), 32'd0);
        wait_cycles(1);
        check("start_after_last", 32'(start_a), 32'd1);
        check("wc_after_prog",    32'(wc_a),    32'd7);
        check("busy_in_run",      32'(busy_a),  32'd0);
        check("prog_sb_drained",  32'(q_a.size()), 32'd0);

        // RUN ignores further input.
        w0 = writes_a;
        bad = 0;
        valid_a = 1'b1;
        in_data = 32'hdeadbeef;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (ready_a !== 1'b0) bad++;
        end
        valid_a = 1'b0;
        check("run_ready_low", 32'(bad), 32'd0);
        check("run_no_writes", 32'(writes_a - w0), 32'd0);

        // Single word program.
        do_reset();
        w0 = writes_a;
        send_word(32'h007302b3, 1'b1);
        wait_cycles(5);
        check("single_we_pulses", 32'(writes_a - w0), 32'd4);
        check("single_start",     32'(start_a), 32'd1);
        check("single_ready",     32'(ready_a), 32'd0);
        check("single_drained",   32'(q_a.size()), 32'd0);

        // Back-to-back words with in_valid held high.
        do_reset();
        k = 0;
        in_last = 1'b0;
        in_data = cw[0];
        valid_a = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            check("ready_pattern", 32'(ready_a), 32'(i % 5 == 0));
            if (ready_a && k < 3) begin
                check("wc_at_accept", 32'(wc_a), 32'(k));
                push_word(cw[k]);
                k++;
            end
            @(posedge clock);
            #1;
            if (k < 3) in_data = cw[k];
            else       valid_a = 1'b0;
        end
        check("stream_wc", 32'(wc_a), 32'd3);
        check("stream_drained", 32'(q_a.size()), 32'd0);

        // Reset during the second byte of word 2.
        do_reset();
        send_word(32'h11223344, 1'b0);
        send_word(32'h55667788, 1'b0);
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(1);
        check("midrst_we",   32'(we_a),   32'd0);
        check("midrst_wc",   32'(wc_a),   32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_bytes_left", 32'(q_a.size()), 32'd2);
        q_a.delete();
        reset = 1'b0;
        exp_count = 0;
        send_word(32'h99aabbcc, 1'b0);
        wait_cycles(5);
        check("reload_wc", 32'(wc_a), 32'd1);
        check("reload_drained", 32'(q_a.size()), 32'd0);

        // Small memory: fourth word overflows.
        do_reset();
        sel = 1'b1;
        w0 = writes_b;
        for (int i = 0; i < 3; i++) send_word(cw[i], 1'b0);
        send_word(32'hcafef00d, 1'b1);
        check("ovf_error", 32'(err_b),   32'd1);
        check("ovf_we",    32'(we_b),    32'd0);
        check("ovf_start", 32'(start_b), 32'd0);
        check("ovf_wc",    32'(wc_b),    32'd3);
        wait_cycles(5);
        check("ovf_writes",  32'(writes_b - w0), 32'd12);
        check("ovf_ready",   32'(ready_b), 32'd0);
        check("ovf_sticky",  32'(err_b),   32'd1);
        check("ovf_start_2", 32'(start_b), 32'd0);
        check("ovf_drained", 32'(q_b.size()), 32'd0);
        sel = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        send_word(32'hffff0000, 1'b0);
        send_word(32'h0000ffff, 1'b1);
        wait_cycles(5);
        check("csum_start", 32'(start_a), 32'd1);
        check("csum_value", csum_a, 32'hffffffff);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
